// File: rtl/pipe_divider_pkg.sv
// pipe_divider_pkg
// Shared widths, the per-stage pipeline record, the output record and the
// conditional-negate helpers used by the pipelined restoring divider.
//   DW   : dividend / quotient width
//   VW   : divisor / remainder width
//   TAGW : opaque tag width
//   PW   : partial-remainder width (one guard bit above the divisor)
package pipe_divider_pkg;

  localparam int unsigned DW   = 16;
  localparam int unsigned VW   = 8;
  localparam int unsigned TAGW = 4;
  localparam int unsigned PW   = VW + 1;

  // One restoring-divider stage worth of in-flight state.
  typedef struct packed {
    logic            valid;
    logic [PW-1:0]   part;    // partial remainder
    logic [DW-1:0]   quo;     // quotient bits produced so far (LSB = newest)
    logic [DW-1:0]   resid;   // dividend bits not yet consumed, MSB next
    logic [VW-1:0]   dvsr;    // |divisor|
    logic            qsign;   // negate quotient in fix-up
    logic            rsign;   // negate remainder in fix-up
    logic            div0;
    logic            ovf;
    logic [TAGW-1:0] tag;
  } stage_t;

  // Final result as presented on the output ports.
  typedef struct packed {
    logic            valid;
    logic [DW-1:0]   quo;
    logic [VW-1:0]   rem;
    logic [TAGW-1:0] tag;
    logic            div0;
    logic            ovf;
  } result_t;

  // Two's-complement negate of a DW-wide value when en is set.
  function automatic logic [DW-1:0] neg_dw(input logic en, input logic [DW-1:0] x);
    logic [DW-1:0] r;
    if (en) begin
      r = ~x + {{(DW-1){1'b0}}, 1'b1};
    end else begin
      r = x;
    end
    return r;
  endfunction

  // Two's-complement negate of a VW-wide value when en is set.
  function automatic logic [VW-1:0] neg_vw(input logic en, input logic [VW-1:0] x);
    logic [VW-1:0] r;
    if (en) begin
      r = ~x + {{(VW-1){1'b0}}, 1'b1};
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_divider_stage.sv
// div_stage
// One restoring division step: shift the next dividend bit into the partial
// remainder, subtract |divisor| if it fits, and append the quotient bit.
// The stage register holds when adv_i is low and loads zeros for a bubble.
//   clk_i    : clock
//   rst_ni   : synchronous active-low reset
//   adv_i    : global pipeline advance enable
//   stage_i  : record from the previous stage
//   stage_o  : registered record after this step
module div_stage
  import pipe_divider_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   adv_i,
  input  stage_t stage_i,
  output stage_t stage_o
);

  stage_t        stage_d;
  stage_t        stage_q;
  logic [PW-1:0] shifted_s;
  logic          fits_s;

  // Restoring step on the incoming record; bubbles become all-zero.
  always_comb begin
    stage_d   = stage_i;
    shifted_s = {stage_i.part[VW-1:0], stage_i.resid[DW-1]};
    fits_s    = (shifted_s >= {1'b0, stage_i.dvsr});
    if (stage_i.valid) begin
      if (fits_s) begin
        stage_d.part = shifted_s - {1'b0, stage_i.dvsr};
      end else begin
        stage_d.part = shifted_s;
      end
      stage_d.quo   = {stage_i.quo[DW-2:0], fits_s};
      stage_d.resid = {stage_i.resid[DW-2:0], 1'b0};
    end else begin
      stage_d = '0;
    end
  end

  // Stage register: reset clears, stall holds, otherwise load.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else if (adv_i) begin
      stage_q <= stage_d;
    end else begin
      stage_q <= stage_q;
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/pipe_divider.sv
// pipe_divider
// Fully pipelined signed/unsigned integer divider. One transaction per cycle,
// DW+2 cycles latency (pre stage, DW restoring stages, fix-up stage).
// The whole pipeline stalls while a result is presented but not accepted.
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   in_valid_i/in_ready_o  : input handshake (in_ready_o = pipeline advance)
//   in_signed_i            : 1 = two's-complement operands
//   in_dividend_i (DW)     : dividend
//   in_divisor_i  (VW)     : divisor
//   in_tag_i      (TAGW)   : tag returned with the result
//   out_valid_o/out_ready_i: output handshake
//   out_quotient_o (DW), out_remainder_o (VW), out_tag_o (TAGW)
//   out_div0_o             : divisor was zero
//   out_ovf_o              : signed most-negative / -1
module pipe_divider
  import pipe_divider_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic            in_signed_i,
  input  logic [DW-1:0]   in_dividend_i,
  input  logic [VW-1:0]   in_divisor_i,
  input  logic [TAGW-1:0] in_tag_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [DW-1:0]   out_quotient_o,
  output logic [VW-1:0]   out_remainder_o,
  output logic [TAGW-1:0] out_tag_o,
  output logic            out_div0_o,
  output logic            out_ovf_o
);

  logic    adv_s;
  logic    dvd_neg_s;
  logic    dvs_neg_s;
  stage_t  pre_d;
  stage_t  pre_q;
  stage_t  chain_s [DW+1];
  result_t fix_d;
  result_t fix_q;
  stage_t  last_s;
  logic    unused_s;

  // Only a presented-but-refused result blocks the pipeline.
  assign adv_s      = !(fix_q.valid && !out_ready_i);
  assign in_ready_o = adv_s;

  assign dvd_neg_s = in_signed_i && in_dividend_i[DW-1];
  assign dvs_neg_s = in_signed_i && in_divisor_i[VW-1];

  // Pre stage: magnitudes, result signs and exception flags.
  always_comb begin
    pre_d = '0;
    if (in_valid_i) begin
      pre_d.valid = 1'b1;
      pre_d.resid = neg_dw(dvd_neg_s, in_dividend_i);
      pre_d.dvsr  = neg_vw(dvs_neg_s, in_divisor_i);
      pre_d.qsign = dvd_neg_s ^ dvs_neg_s;
      pre_d.rsign = dvd_neg_s;
      pre_d.div0  = (in_divisor_i == {VW{1'b0}});
      pre_d.ovf   = in_signed_i
                    && (in_dividend_i == {1'b1, {(DW-1){1'b0}}})
                    && (in_divisor_i == {VW{1'b1}});
      pre_d.tag   = in_tag_i;
    end else begin
      pre_d = '0;
    end
  end

  // Pre stage register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pre_q <= '0;
    end else if (adv_s) begin
      pre_q <= pre_d;
    end else begin
      pre_q <= pre_q;
    end
  end

  assign chain_s[0] = pre_q;

  for (genvar g = 0; g < DW; g++) begin : g_stage
    div_stage u_stage (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .adv_i   (adv_s),
      .stage_i (chain_s[g]),
      .stage_o (chain_s[g+1])
    );
  end

  assign last_s = chain_s[DW];

  // Consumed dividend, guard bit and |divisor| are not needed after the last step.
  assign unused_s = ^{last_s.resid, last_s.dvsr, last_s.part[VW]};

  // Fix-up stage: div0 beats ovf beats ordinary sign correction.
  always_comb begin
    fix_d = '0;
    if (last_s.valid) begin
      fix_d.valid = 1'b1;
      fix_d.tag   = last_s.tag;
      fix_d.div0  = last_s.div0;
      fix_d.ovf   = last_s.ovf;
      if (last_s.div0) begin
        fix_d.quo = {DW{1'b1}};
        fix_d.rem = {VW{1'b0}};
      end else if (last_s.ovf) begin
        fix_d.quo = {1'b1, {(DW-1){1'b0}}};
        fix_d.rem = {VW{1'b0}};
      end else begin
        fix_d.quo = neg_dw(last_s.qsign, last_s.quo);
        fix_d.rem = neg_vw(last_s.rsign, last_s.part[VW-1:0]);
      end
    end else begin
      fix_d = '0;
    end
  end

  // Output register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fix_q <= '0;
    end else if (adv_s) begin
      fix_q <= fix_d;
    end else begin
      fix_q <= fix_q;
    end
  end

  assign out_valid_o     = fix_q.valid;
  assign out_quotient_o  = fix_q.quo;
  assign out_remainder_o = fix_q.rem;
  assign out_tag_o       = fix_q.tag;
  assign out_div0_o      = fix_q.div0;
  assign out_ovf_o       = fix_q.ovf;

endmodule

// File: tb/tb_pipe_divider.sv
// tb_pipe_divider
// Scoreboard bench: the driver pushes expected results when a transaction is
// accepted; a negedge monitor pops and compares on every output handshake.
module tb_pipe_divider;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic [3:0]  tag;
    logic        d0;
    logic        ov;
    bit          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_signed;
  logic [15:0] in_dividend;
  logic [7:0]  in_divisor;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_quotient;
  logic [7:0]  out_remainder;
  logic [3:0]  out_tag;
  logic        out_div0;
  logic        out_ovf;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  bit          rnd_ready = 1'b0;
  bit          held = 1'b0;
  logic [29:0] held_val;

  pipe_divider dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .in_signed_i     (in_signed),
    .in_dividend_i   (in_dividend),
    .in_divisor_i    (in_divisor),
    .in_tag_i        (in_tag),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_quotient_o  (out_quotient),
    .out_remainder_o (out_remainder),
    .out_tag_o       (out_tag),
    .out_div0_o      (out_div0),
    .out_ovf_o       (out_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // Reference model written from the arithmetic definition.
  function automatic exp_t model(input logic sgn, input logic [15:0] a,
                                 input logic [7:0] b, input logic [3:0] tag);
    exp_t e;
    int   sa;
    int   sbv;
    e.tag = tag; e.d0 = 1'b0; e.ov = 1'b0; e.lat = 1'b0; e.acc = 0;
    if (b == 8'd0) begin
      e.q = 16'hFFFF; e.r = 8'h00; e.d0 = 1'b1;
    end else if (sgn && a == 16'h8000 && b == 8'hFF) begin
      e.q = 16'h8000; e.r = 8'h00; e.ov = 1'b1;
    end else if (sgn) begin
      sa  = $signed(a);
      sbv = $signed(b);
      e.q = 16'(sa / sbv);
      e.r = 8'(sa % sbv);
    end else begin
      e.q = a / {8'd0, b};
      e.r = 8'(a % {8'd0, b});
    end
    return e;
  endfunction

  // Present one transaction (called #1 after a posedge); returns #1 after the accepting edge.
  task automatic send(input logic sgn, input logic [15:0] a, input logic [7:0] b,
                      input exp_t e);
    bit done = 1'b0;
    in_valid = 1'b1; in_signed = sgn; in_dividend = a; in_divisor = b; in_tag = e.tag;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.acc = cyc;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
    end
  endtask

  function automatic exp_t mk(input logic [15:0] q, input logic [7:0] r, input logic [3:0] tag,
                              input logic d0, input logic ov);
    exp_t e;
    e.q = q; e.r = r; e.tag = tag; e.d0 = d0; e.ov = ov; e.lat = 1'b1; e.acc = 0;
    return e;
  endfunction

  // Output-ready driver: always ready unless random backpressure is enabled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end
  end

  // Monitor: handshake rule, hold stability and scoreboard comparison.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("in_ready_rule", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
        if (held && out_valid)
          chk("hold_stable", {2'd0, out_quotient, out_remainder, out_tag, out_div0, out_ovf},
              {2'd0, held_val});
        held     = out_valid && !out_ready;
        held_val = {out_quotient, out_remainder, out_tag, out_div0, out_ovf};
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_output actual=valid required=none");
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("quotient",  {16'd0, out_quotient},  {16'd0, e.q});
            chk("remainder", {24'd0, out_remainder}, {24'd0, e.r});
            chk("tag",       {28'd0, out_tag},       {28'd0, e.tag});
            chk("div0",      {31'd0, out_div0},      {31'd0, e.d0});
            chk("ovf",       {31'd0, out_ovf},       {31'd0, e.ov});
            if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd18);
          end
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  // Main sequence.
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
    in_dividend = 16'd0; in_divisor = 8'd0; in_tag = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_quotient",  {16'd0, out_quotient}, 32'd0);
    chk("reset_in_ready",  {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Single unsigned transaction with latency check.
    send(1'b0, 16'd1000, 8'd7, mk(16'd142, 8'd6, 4'd3, 1'b0, 1'b0));
    drain();

    // Directed vectors back to back.
    send(1'b1, 16'hFC18, 8'h07, mk(16'hFF72, 8'hFA, 4'd5, 1'b0, 1'b0));
    send(1'b1, 16'h03E8, 8'hF9, mk(16'hFF72, 8'h06, 4'd6, 1'b0, 1'b0));
    send(1'b0, 16'h04D2, 8'h00, mk(16'hFFFF, 8'h00, 4'd7, 1'b1, 1'b0));
    send(1'b1, 16'h8000, 8'hFF, mk(16'h8000, 8'h00, 4'd8, 1'b0, 1'b1));
    send(1'b0, 16'hFFFF, 8'hFF, mk(16'h0101, 8'h00, 4'd9, 1'b0, 1'b0));
    send(1'b1, 16'hFFF9, 8'h02, mk(16'hFFFD, 8'hFF, 4'hA, 1'b0, 1'b0));
    send(1'b0, 16'h8000, 8'hFF, mk(16'h0080, 8'h80, 4'hB, 1'b0, 1'b0));
    send(1'b1, 16'hFFFF, 8'h80, mk(16'h0000, 8'hFF, 4'hC, 1'b0, 1'b0));
    drain();

    // Random stream with backpressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      logic        sg;
      logic [15:0] a;
      logic [7:0]  b;
      sg = 1'($urandom_range(0, 1));
      a  = 16'($urandom);
      b  = 8'($urandom);
      if ($urandom_range(0, 15) == 0) b = 8'd0;
      if ($urandom_range(0, 15) == 0) begin sg = 1'b1; a = 16'h8000; b = 8'hFF; end
      send(sg, a, b, model(sg, a, b, 4'(i)));
    end
    drain();
    rnd_ready = 1'b0;
    @(posedge clk); #1;

    // Reset with ten transactions in flight.
    for (int i = 0; i < 10; i++) begin
      logic [15:0] a;
      a = 16'(100 * (i + 1));
      send(1'b0, a, 8'd3, model(1'b0, a, 8'd3, 4'(i)));
    end
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_outputs", {2'd0, out_quotient, out_remainder, out_tag, out_div0, out_ovf}, 32'd0);
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    send(1'b1, 16'hFC18, 8'hF9, mk(16'd142, 8'hFA, 4'hE, 1'b0, 1'b0));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
